tanh_pwl_pipe: RTL and testbench
================================

// Module: tanh_pwl_pipe
// PURPOSE
//  Pipelined, parametrised piecewise-linear tanh/sigmoid activation unit for the accelerator datapath.
//  Takes signed fixed-point samples over a valid/ready stream and returns a signed Q1.(OUT_W-1) result after 3 stages.
//  Uses shift-only slopes with odd symmetry, and adds a per-sample sigmoid mode and a saturation event counter.
// PARAMETERS
//  IN_W     16  input width, signed two's complement; IN_W-IN_FRAC >= 3
//  IN_FRAC  12  input fraction bits (default Q4.12); IN_FRAC >= 8 and IN_FRAC >= OUT_W-1
//  OUT_W    8   output width, signed Q1.(OUT_W-1)
//  CNT_W    16  saturation counter width
// PORTS
//  clk_i        in   1        clock, all state on rising edge
//  rst_i        in   1        synchronous, active-high reset
//  in_valid_i   in   1        input sample valid
//  in_ready_o   out  1        input accepted when in_valid_i & in_ready_o
//  in_data_i    in   IN_W     signed input sample x
//  in_mode_i    in   1        0 = tanh, 1 = sigmoid; sampled with the input beat
//  out_valid_o  out  1        result valid
//  out_ready_i  in   1        downstream accepts result
//  out_data_o   out  OUT_W    signed Q1.(OUT_W-1) result
//  clr_cnt_i    in   1        synchronous clear of sat_cnt_o
//  sat_cnt_o    out  CNT_W    number of saturated results delivered
// BEHAVIOUR
//  Reset: all stage valids = 0, out_valid_o = 0, out_data_o = 0, sat_cnt_o = 0. in_ready_o = 1 on the first cycle after reset.
//  Reset mid-stream discards all in-flight samples. No output beat follows.
//  Pipeline: S1, S2, S3 each hold a valid bit. Stage k loads when !valid_k || (stage k+1 loads); S3 loads when !out_valid_o || out_ready_i.
//   in_ready_o = S1 load enable. Bubbles collapse. Latency is 3 cycles from input handshake to out_valid_o with no backpressure.
//   Throughput is 1/cycle. Order is preserved. out_data_o is held stable while out_valid_o & !out_ready_i.
//  S1: x_eff = x (tanh) or x>>>1 (sigmoid, arithmetic). Compute sign s = x_eff[IN_W-1] and magnitude m = |x_eff|.
//   If x_eff = -2^(IN_W-1), force segment 5. Select segment from m, with all constants at IN_FRAC fraction bits:
//   seg1 m<0.25; seg2 0.25<=m<0.875; seg3 0.875<=m<1.875; seg4 1.875<=m<3.0; seg5 m>=3.0.
//  S2: magnitude t (IN_FRAC fraction bits, unsigned):
//   seg1 t=m; seg2 t=m-(m>>2)+0.0625; seg3 t=(m>>2)+0.5; seg4 t=(m>>5)+233/256; seg5 t=ONE (1.0).
//   Clip t to ONE. Flag sat=1 for seg5 only.
//  S3, tanh mode: round t to OUT_W-1 fraction bits, half-up on the magnitude (add 2^(IN_FRAC-OUT_W), then drop IN_FRAC-OUT_W+1 bits).
//   Clip to 2^(OUT_W-1)-1, then negate if s. Result range is symmetric ±(2^(OUT_W-1)-1); -2^(OUT_W-1) is never produced.
//  S3, sigmoid mode: signed v = s ? -t : t; u = (v + ONE) >> 1, which is >= 0. Round u half-up as above and clip to 2^(OUT_W-1)-1.
//   Result range is 0..2^(OUT_W-1)-1.
//  Internal widths must hold ONE + ONE without overflow (IN_W+2 bits minimum).
//  sat_cnt_o: +1 on each output handshake whose sample has sat=1. Saturates at all-ones (no wrap).
//   clr_cnt_i wins over a simultaneous increment; count becomes 0.
//  All segment boundaries are inclusive on the lower edge.
//   The defaults give a continuous curve at 0.25, 0.875 and 1.875, with a small step at 3.0 absorbed by the clip.
// TESTING (defaults: Q4.12 in, Q1.7 out)
//  tanh: x=0x0000->0x00; 0x0400->0x20; 0xFC00->0xE0; 0x1000->0x60; 0xF000->0xA0.
//  tanh: x=0x2000->0x7D (124.5 rounds up); x=0x3000->0x7F with sat_cnt +1; x=0x8000->0x81 with sat_cnt +1.
//  sigmoid: x=0x0000->0x40; 0x2000->0x70; 0xA000->0x00 with sat_cnt +1; 0x7FFF->0x7F with sat_cnt +1.
//  Backpressure: out_ready_i=0 for 6 cycles while 5 samples are offered -> exactly 3 accepted, in_ready_o=0 afterwards,
//   out_data_o stable; on release all outputs arrive in order, 1/cycle.
//  Bubbles: alternate in_valid_i with out_ready_i toggling -> no loss or duplication; results match the scoreboard.
//  Counter: saturate at 0xFFFF and hold; clr_cnt_i in the same cycle as a sat handshake -> 0.
//   rst_i with 3 samples in flight -> out_valid_o=0 next cycle and no stale beats.

Source files
------------

// File: rtl/tanh_pwl_pipe_if.sv
// Stream interface for the piecewise-linear activation unit.
// Signal names carry their direction as seen from the activation unit.
//   in_valid_i / in_ready_o / in_data_i / in_mode_i : input sample beat
//   out_valid_o / out_ready_i / out_data_o          : result beat
// master : the side that produces samples and consumes results
// slave  : the activation unit itself
interface tanh_pwl_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8
) ();
   logic              in_valid_i;
   logic              in_ready_o;
   logic [IN_W-1:0]   in_data_i;
   logic              in_mode_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [OUT_W-1:0]  out_data_o;

   modport master (
      output in_valid_i, in_data_i, in_mode_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i, in_mode_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/tanh_pwl_pipe.sv
// Three-stage piecewise-linear tanh / sigmoid activation unit.
// Input is signed fixed point with IN_FRAC fraction bits, output is signed
// Q1.(OUT_W-1). Slopes are shift-only and the curve uses odd symmetry around 0;
// sigmoid is derived as (tanh(x/2) + 1) / 2. Saturated results delivered
// downstream are counted in a saturating event counter.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   bus        stream interface (slave side): sample in, result out
//   clr_cnt_i  synchronous clear of the saturation counter (wins over increment)
//   sat_cnt_o  number of saturated results handed downstream
module tanh_pwl_pipe #(
   parameter int IN_W    = 16,
   parameter int IN_FRAC = 12,
   parameter int OUT_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   tanh_pwl_pipe_if.slave     bus,
   input  logic               clr_cnt_i,
   output logic [CNT_W-1:0]   sat_cnt_o
);

   // Two guard bits so ONE + ONE and negated magnitudes never overflow.
   localparam int W = IN_W + 2;

   localparam logic [W-1:0] ONE    = W'(1)   << IN_FRAC;
   localparam logic [W-1:0] TH_Q   = W'(1)   << (IN_FRAC - 2);   // 0.25
   localparam logic [W-1:0] TH_78  = W'(7)   << (IN_FRAC - 3);   // 0.875
   localparam logic [W-1:0] TH_158 = W'(15)  << (IN_FRAC - 3);   // 1.875
   localparam logic [W-1:0] TH_3   = W'(3)   << IN_FRAC;         // 3.0
   localparam logic [W-1:0] C_16   = W'(1)   << (IN_FRAC - 4);   // 0.0625
   localparam logic [W-1:0] C_H    = W'(1)   << (IN_FRAC - 1);   // 0.5
   localparam logic [W-1:0] C_233  = W'(233) << (IN_FRAC - 8);   // 233/256

   // Output rounding: drop SH bits, half-up. RND collapses to 0 when SH = 0.
   localparam int           SH     = IN_FRAC - OUT_W + 1;
   localparam logic [W-1:0] RND    = (W'(1) << SH) >> 1;
   localparam logic [W-1:0] MAXO   = W'((1 << (OUT_W - 1)) - 1);

   localparam logic [IN_W-1:0] X_MIN = {1'b1, {(IN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      SEG1 = 3'd0,
      SEG2 = 3'd1,
      SEG3 = 3'd2,
      SEG4 = 3'd3,
      SEG5 = 3'd4
   } seg_e;

   // Pipeline control
   logic ld1, ld2, ld3;
   logic v1_q, v2_q, v3_q;

   // Stage 1 registers
   logic          s1_q;
   logic          mode1_q;
   logic [W-1:0]  m1_q;
   seg_e          seg1_q;

   // Stage 2 registers
   logic          s2_q;
   logic          mode2_q;
   logic [W-1:0]  t2_q;
   logic          sat2_q;

   // Stage 3 (output) registers
   logic [OUT_W-1:0] data3_q;
   logic             sat3_q;
   logic [CNT_W-1:0] sat_cnt_q;

   // Stage combinational results
   logic signed [IN_W-1:0] x_eff;
   logic [W-1:0]           x_ext;
   logic                   s_d;
   logic [W-1:0]           m_d;
   seg_e                   seg_d;
   logic [W-1:0]           t_raw;
   logic [W-1:0]           t_d;
   logic                   sat_d;
   logic [W-1:0]           v_d;
   logic [W-1:0]           u_d;
   logic [OUT_W-1:0]       mag_d;
   logic [OUT_W-1:0]       y_d;

   // Rounds a magnitude with IN_FRAC fraction bits to OUT_W-1 fraction bits
   // and clips it to the largest positive output code.
   function automatic logic [OUT_W-1:0] rnd_clip(input logic [W-1:0] a);
      logic [W-1:0] r;
      r = (a + RND) >> SH;
      if (r > MAXO) begin
         r = MAXO;
      end
      return r[OUT_W-1:0];
   endfunction

   // Each stage advances when it is empty or its successor advances, so a
   // bubble anywhere is squeezed out by the next upstream beat.
   always_comb begin
      ld3 = !v3_q || bus.out_ready_i;
      ld2 = !v2_q || ld3;
      ld1 = !v1_q || ld2;
   end

   assign bus.in_ready_o  = ld1;
   assign bus.out_valid_o = v3_q;
   assign bus.out_data_o  = data3_q;
   assign sat_cnt_o       = sat_cnt_q;

   // S1: mode prescale, sign/magnitude split and segment select
   always_comb begin
      x_eff = bus.in_mode_i ? ($signed(bus.in_data_i) >>> 1)
                            : $signed(bus.in_data_i);
      x_ext = {{2{x_eff[IN_W-1]}}, x_eff};
      s_d   = x_eff[IN_W-1];
      m_d   = s_d ? (~x_ext + 1'b1) : x_ext;
      seg_d = SEG1;
      if (x_eff == X_MIN) begin
         seg_d = SEG5;
      end else if (m_d >= TH_3) begin
         seg_d = SEG5;
      end else if (m_d >= TH_158) begin
         seg_d = SEG4;
      end else if (m_d >= TH_78) begin
         seg_d = SEG3;
      end else if (m_d >= TH_Q) begin
         seg_d = SEG2;
      end
   end

   // S2: segment evaluation on the magnitude, clipped to 1.0
   always_comb begin
      t_raw = ONE;
      case (seg1_q)
         SEG1:    t_raw = m1_q;
         SEG2:    t_raw = m1_q - (m1_q >> 2) + C_16;
         SEG3:    t_raw = (m1_q >> 2) + C_H;
         SEG4:    t_raw = (m1_q >> 5) + C_233;
         default: t_raw = ONE;
      endcase
      t_d   = (t_raw > ONE) ? ONE : t_raw;
      sat_d = (seg1_q == SEG5);
   end

   // S3: tanh restores the sign after rounding so the code range stays
   // symmetric; sigmoid shifts the signed value into 0..1 before rounding.
   // v + ONE lies in 0..2*ONE, so the modular add below is exact.
   always_comb begin
      v_d   = s2_q ? (~t2_q + 1'b1) : t2_q;
      u_d   = (v_d + ONE) >> 1;
      mag_d = '0;
      y_d   = '0;
      if (mode2_q) begin
         mag_d = rnd_clip(u_d);
         y_d   = mag_d;
      end else begin
         mag_d = rnd_clip(t2_q);
         y_d   = s2_q ? (~mag_d + 1'b1) : mag_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q    <= 1'b0;
         s1_q    <= 1'b0;
         mode1_q <= 1'b0;
         m1_q    <= '0;
         seg1_q  <= SEG1;
      end else if (ld1) begin
         v1_q <= bus.in_valid_i;
         if (bus.in_valid_i) begin
            s1_q    <= s_d;
            mode1_q <= bus.in_mode_i;
            m1_q    <= m_d;
            seg1_q  <= seg_d;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v2_q    <= 1'b0;
         s2_q    <= 1'b0;
         mode2_q <= 1'b0;
         t2_q    <= '0;
         sat2_q  <= 1'b0;
      end else if (ld2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            s2_q    <= s1_q;
            mode2_q <= mode1_q;
            t2_q    <= t_d;
            sat2_q  <= sat_d;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v3_q    <= 1'b0;
         data3_q <= '0;
         sat3_q  <= 1'b0;
      end else if (ld3) begin
         v3_q <= v2_q;
         if (v2_q) begin
            data3_q <= y_d;
            sat3_q  <= sat2_q;
         end
      end
   end

   // Counts only beats that actually leave the unit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sat_cnt_q <= '0;
      end else if (clr_cnt_i) begin
         sat_cnt_q <= '0;
      end else if (v3_q && bus.out_ready_i && sat3_q && !(&sat_cnt_q)) begin
         sat_cnt_q <= sat_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
module tb_tanh_pwl_pipe;
   localparam int IN_W    = 16;
   localparam int IN_FRAC = 12;
   localparam int OUT_W   = 8;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             clr_cnt_i;
   logic [CNT_W-1:0] sat_cnt_o;

   tanh_pwl_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   tanh_pwl_pipe #(
      .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus(bus.slave),
      .clr_cnt_i(clr_cnt_i),
      .sat_cnt_o(sat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] y;
      logic       sat;
   } exp_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   exp_t exp_cur;
   int   cnt_m  = 0;
   int   n_out  = 0;
   bit   mon_en = 0;
   bit   hold_pend = 0;
   logic [7:0] hold_data;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Reference: plain integer evaluation of the curve definition, defaults Q4.12 -> Q1.7.
   function automatic void ref_model(input logic [15:0] x, input logic mode,
                                     output logic [7:0] y, output logic sat);
      int xv, xe, m, t, v, u, r;
      bit neg;
      xv  = int'($signed(x));
      xe  = mode ? (xv >>> 1) : xv;
      neg = (xe < 0);
      m   = neg ? -xe : xe;
      sat = 1'b0;
      if (m < 1024)       t = m;
      else if (m < 3584)  t = m - m / 4 + 256;
      else if (m < 7680)  t = m / 4 + 2048;
      else if (m < 12288) t = m / 32 + 3728;
      else begin
         t   = 4096;
         sat = 1'b1;
      end
      if (t > 4096) t = 4096;
      if (!mode) begin
         r = (t + 16) / 32;
         if (r > 127) r = 127;
         y = neg ? 8'(-r) : 8'(r);
      end else begin
         v = neg ? -t : t;
         u = (v + 4096) / 2;
         r = (u + 16) / 32;
         if (r > 127) r = 127;
         y = 8'(r);
      end
   endfunction

   // Scoreboard / counter model, sampled mid-cycle while all handshake signals are settled.
   always @(negedge clk_i) begin
      exp_t e;
      if (mon_en) begin
         check_eq("sat_cnt", 32'(sat_cnt_o), 32'(cnt_m));
         if (hold_pend) check_eq("out_hold", 32'(bus.out_data_o), 32'(hold_data));
         hold_pend = bus.out_valid_o && !bus.out_ready_i && !rst_i;
         hold_data = bus.out_data_o;
         if (rst_i) begin
            sb_q.delete();
            cnt_m = 0;
         end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
               if (sb_q.size() == 0) begin
                  check_eq("spurious_beat", 32'(sb_q.size()), 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("out_data", 32'(bus.out_data_o), 32'(e.y));
                  n_out++;
                  if (!clr_cnt_i && e.sat && cnt_m < CNT_MAX) cnt_m++;
               end
            end
            if (clr_cnt_i) cnt_m = 0;
            if (bus.in_valid_i && bus.in_ready_o) sb_q.push_back(exp_cur);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [15:0] x, input logic mode, input logic [7:0] y, input logic sat);
      logic acc;
      int   k;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = x;
      bus.in_mode_i  = mode;
      exp_cur        = '{y: y, sat: sat};
      k = 0;
      do begin
         @(negedge clk_i);
         acc = bus.in_ready_o;
         tick();
         k++;
      end while (!acc && k < 200);
      if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
      bus.in_valid_i = 1'b0;
   endtask

   task automatic send_ref(input logic [15:0] x, input logic mode);
      logic [7:0] y;
      logic       s;
      ref_model(x, mode, y, s);
      send(x, mode, y, s);
   endtask

   task automatic drain();
      int k;
      bus.out_ready_i = 1'b1;
      k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         tick();
         k++;
      end
      tick();
      check_eq("drain", 32'(sb_q.size()), 32'd0);
   endtask

   function automatic logic [15:0] rand_x();
      logic [15:0] bnd [10];
      logic [15:0] x;
      bnd = '{16'h0400, 16'h03FF, 16'h0E00, 16'h0DFF, 16'h1E00,
              16'h1DFF, 16'h3000, 16'h2FFF, 16'h8000, 16'h7FFF};
      if ($urandom_range(0, 2) == 0) begin
         x = bnd[$urandom_range(0, 9)];
         if ($urandom_range(0, 1) == 1) x = -x;
      end else begin
         x = 16'($urandom_range(0, 65535));
      end
      return x;
   endfunction

   logic [15:0] dx [13] = '{16'h0000, 16'h0400, 16'hFC00, 16'h1000, 16'hF000, 16'h2000, 16'h3000,
                            16'h8000, 16'h0000, 16'h2000, 16'hA000, 16'h7FFF, 16'h03FF};
   logic        dm [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [7:0]  dy [13] = '{8'h00, 8'h20, 8'hE0, 8'h60, 8'hA0, 8'h7D, 8'h7F,
                            8'h81, 8'h40, 8'h70, 8'h00, 8'h7F, 8'h20};
   logic        ds [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

   initial begin
      logic [15:0] bpx [5];
      logic [7:0]  y;
      logic        s;
      int          idx, lat, sent, base;
      bit          pend;

      rst_i = 1'b1;
      clr_cnt_i = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.in_data_i = '0;
      bus.in_mode_i = 1'b0;
      bus.out_ready_i = 1'b1;
      exp_cur = '0;
      tick();
      tick();
      mon_en = 1;
      tick();
      rst_i = 1'b0;

      @(negedge clk_i);
      check_eq("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check_eq("rst_out_data", 32'(bus.out_data_o), 32'd0);
      check_eq("rst_sat_cnt", 32'(sat_cnt_o), 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      tick();

      // Known points of the curve, back to back
      for (int i = 0; i < 13; i++) send(dx[i], dm[i], dy[i], ds[i]);
      drain();

      // Latency from an isolated handshake
      send_ref(16'h0400, 1'b0);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!bus.out_valid_o && lat < 10);
      check_eq("latency", 32'(lat), 32'd3);
      tick();
      drain();

      // Backpressure: 6 stalled cycles with 5 samples offered
      for (int i = 0; i < 5; i++) bpx[i] = rand_x();
      bus.out_ready_i = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         bus.in_valid_i = (idx < 5);
         bus.in_data_i  = bpx[idx < 5 ? idx : 4];
         bus.in_mode_i  = 1'b0;
         ref_model(bus.in_data_i, 1'b0, y, s);
         exp_cur = '{y: y, sat: s};
         @(negedge clk_i);
         if (bus.in_valid_i && bus.in_ready_o) idx++;
         tick();
      end
      check_eq("bp_accepted", 32'(idx), 32'd3);
      @(negedge clk_i);
      check_eq("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      check_eq("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
      tick();
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bus.in_valid_i = (idx < 5);
         bus.in_data_i  = bpx[idx < 5 ? idx : 4];
         ref_model(bus.in_data_i, 1'b0, y, s);
         exp_cur = '{y: y, sat: s};
         @(negedge clk_i);
         check_eq("bp_stream", 32'(bus.out_valid_o), 32'd1);
         if (bus.in_valid_i && bus.in_ready_o) idx++;
         tick();
      end
      bus.in_valid_i = 1'b0;
      check_eq("bp_all_sent", 32'(idx), 32'd5);
      drain();

      // Bubbles: alternating pattern first, then random valid/ready
      base = n_out;
      sent = 0;
      pend = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pend && ((c < 40) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0))) begin
            bus.in_data_i  = rand_x();
            bus.in_mode_i  = 1'($urandom_range(0, 1));
            ref_model(bus.in_data_i, bus.in_mode_i, y, s);
            exp_cur = '{y: y, sat: s};
            bus.in_valid_i = 1'b1;
            pend = 1;
         end
         bus.out_ready_i = (c < 40) ? ((c / 2) % 2 == 0) : ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         if (bus.in_valid_i && bus.in_ready_o) begin
            pend = 0;
            sent++;
         end
         tick();
         if (!pend) bus.in_valid_i = 1'b0;
      end
      bus.in_valid_i = 1'b0;
      drain();
      check_eq("bubble_beats", 32'(n_out - base), 32'(sent));

      // Saturation counter: run past full scale, then clear during a sat beat
      for (int i = 0; i < CNT_MAX + 8; i++) send(16'h3000, 1'b0, 8'h7F, 1'b1);
      drain();
      @(negedge clk_i);
      check_eq("cnt_saturated", 32'(sat_cnt_o), 32'(CNT_MAX));
      tick();
      for (int i = 0; i < 6; i++) send(16'hD000, 1'b0, 8'h81, 1'b1);
      clr_cnt_i = 1'b1;
      @(negedge clk_i);
      check_eq("clr_hs", 32'(bus.out_valid_o && bus.out_ready_i), 32'd1);
      tick();
      clr_cnt_i = 1'b0;
      @(negedge clk_i);
      check_eq("clr_wins", 32'(sat_cnt_o), 32'd0);
      tick();
      drain();

      // Reset with three samples in flight
      for (int i = 0; i < 3; i++) send_ref(rand_x(), 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      check_eq("rst_mid_valid", 32'(bus.out_valid_o), 32'd0);
      check_eq("rst_mid_cnt", 32'(sat_cnt_o), 32'd0);
      tick();
      repeat (8) tick();
      check_eq("rst_no_stale", 32'(sb_q.size()), 32'd0);

      // Post-reset sanity stream
      for (int i = 0; i < 20; i++) send_ref(rand_x(), 1'($urandom_range(0, 1)));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
